// File: rtl/add_out_rx.sv
// Receiver for the adder result stream: capture register, small FIFO with ready/valid drain,
// and running statistics (received/dropped counts, sticky overflow, wrapping accumulator).
module add_out_rx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 in_data,
  input  logic                       in_valid,
  output logic [9:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           rx_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [ACC_W-1:0]           acc,
  input  logic                       clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [9:0]    cap_data;
  logic          cap_vld;
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, rd_nxt;
  logic          empty, full, pop, push, drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && out_ready;
  // A pop on a full FIFO frees the slot in time for the same-cycle push.
  assign push   = cap_vld && (!full || pop);
  assign drop   = cap_vld && full && !pop;
  assign wr_nxt = wr_ptr + PW'(push);
  assign rd_nxt = rd_ptr + PW'(pop);

  assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : 10'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data  <= '0;
      cap_vld   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      cap_data  <= in_data;
      cap_vld   <= in_valid;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      level     <= wr_nxt - rd_nxt;
      out_valid <= (wr_nxt != rd_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cap_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap_vld && rx_cnt != '1) rx_cnt <= rx_cnt + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (push) acc <= acc + ACC_W'(cap_data);
    end
  end

endmodule

// File: tb/tb_add_out_rx.sv
// Directed bench for add_out_rx: stimulus pushes expected words into a queue, a negedge
// monitor pops and compares on every handshake; register-level checks are inline.
module tb_add_out_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  in_data;
  logic        in_valid;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
  logic [9:0]  acc;
  logic        clr;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q [$];

  add_out_rx #(.DEPTH(8), .CNT_W(16), .ACC_W(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt),
    .acc(acc), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: a handshake that completes at the next rising edge consumes the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream: got unexpected word 0x%0h, expected none", out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL stream: got 0x%0h, expected 0x%0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst level", level, 0);
    check("rst out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // 1: single result, two-cycle latency, one-cycle output pulse
    out_ready = 1'b1;
    exp_q.push_back(10'h3FF);
    send(10'h3FF);
    check("t1 valid after E0", out_valid, 0);
    tick();
    check("t1 valid after E1", out_valid, 1);
    check("t1 data", out_data, 'h3FF);
    tick();
    check("t1 valid drops", out_valid, 0);
    check("t1 rx_cnt", rx_cnt, 1);
    check("t1 acc", acc, 'h3FF);

    // 2: fill and overflow
    out_ready = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    check("t2 clr rx_cnt", rx_cnt, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) exp_q.push_back(10'(i));
      send(10'(i));
    end
    tick(); tick();
    check("t2 level", level, 8);
    check("t2 drop_cnt", drop_cnt, 2);
    check("t2 overflow", overflow, 1);
    check("t2 rx_cnt", rx_cnt, 10);
    check("t2 acc", acc, 36);
    check("t2 head stable", out_data, 1);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t2 drained level", level, 0);

    // 3: full FIFO with continuous push and pop
    clr = 1'b1; tick(); clr = 1'b0;
    check("t3 clr overflow", overflow, 0);
    check("t3 clr drop_cnt", drop_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(10'h10 + 10'(i));
      send(10'h10 + 10'(i));
    end
    tick(); tick();
    check("t3 full level", level, 8);
    for (int i = 0; i < 12; i++) begin
      in_data  = 10'h20 + 10'(i);
      in_valid = 1'b1;
      exp_q.push_back(10'h20 + 10'(i));
      if (i == 1) out_ready = 1'b1;
      tick();
      check("t3 level steady", level, 8);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();
    check("t3 level end", level, 8);
    check("t3 drop_cnt", drop_cnt, 0);
    check("t3 rx_cnt", rx_cnt, 20);
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t3 drained level", level, 0);

    // 4: accumulator wrap, then clr coinciding with a capture
    clr = 1'b1; tick(); clr = 1'b0;
    exp_q.push_back(10'h200); send(10'h200);
    exp_q.push_back(10'h200); send(10'h200);
    tick(); tick();
    check("t4 acc wrap", acc, 0);
    check("t4 rx_cnt", rx_cnt, 2);
    check("t4 level", level, 2);
    exp_q.push_back(10'h005);
    send(10'h005);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4 clr acc", acc, 0);
    check("t4 clr rx_cnt", rx_cnt, 0);
    check("t4 clr drop_cnt", drop_cnt, 0);
    check("t4 clr overflow", overflow, 0);
    check("t4 fifo kept", level, 3);
    check("t4 head", out_data, 'h200);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;

    // 5: reset mid-stream
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(10'h0A0 + 10'(i));
      send(10'h0A0 + 10'(i));
    end
    tick(); tick();
    check("t5 level before rst", level, 5);
    check("t5 rx_cnt before rst", rx_cnt, 5);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("t5 rst out_valid", out_valid, 0);
    check("t5 rst out_data", out_data, 0);
    check("t5 rst level", level, 0);
    check("t5 rst rx_cnt", rx_cnt, 0);
    check("t5 rst acc", acc, 0);
    check("t5 rst overflow", overflow, 0);
    check("t5 rst drop_cnt", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    exp_q.push_back(10'h155);
    send(10'h155);
    check("t5 valid after E0", out_valid, 0);
    tick();
    check("t5 valid after E1", out_valid, 1);
    check("t5 data", out_data, 'h155);
    tick();

    // 6: pop requests on an empty FIFO
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6 empty valid", out_valid, 0);
      check("t6 empty level", level, 0);
    end
    exp_q.push_back(10'h2A5);
    send(10'h2A5);
    tick();
    check("t6 push valid", out_valid, 1);
    check("t6 push data", out_data, 'h2A5);
    tick(); tick();
    check("t6 level end", level, 0);
    check("queue empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
